// File: rtl/tcdm_rr_arbiter.sv
// tcdm_rr_arbiter: shares one TCDM master port among NB_REQ requesters.
// Round-robin arbitration that stays locked on a requester while its request
// is waiting for out_gnt_i. An in-order ID FIFO of depth MAX_OUTST records the
// owner of every granted transaction and steers each out_r_valid_i back to it.
// Optional build macro TCDM_ARB_PERF_EN adds per-requester grant counters and
// a counter of cycles in which a request was blocked by a full ID FIFO.
module tcdm_rr_arbiter #(
    parameter int unsigned NB_REQ    = 4,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NB_REQ-1:0]      in_req_i,
    input  logic [NB_REQ*AW-1:0]   in_add_i,
    input  logic [NB_REQ-1:0]      in_wen_i,
    input  logic [NB_REQ*DW/8-1:0] in_be_i,
    input  logic [NB_REQ*DW-1:0]   in_data_i,
    output logic [NB_REQ-1:0]      in_gnt_o,
    output logic [DW-1:0]          in_r_data_o,
    output logic [NB_REQ-1:0]      in_r_valid_o,
    output logic                   out_req_o,
    output logic [AW-1:0]          out_add_o,
    output logic                   out_wen_o,
    output logic [DW/8-1:0]        out_be_o,
    output logic [DW-1:0]          out_data_o,
    input  logic                   out_gnt_i,
    input  logic [DW-1:0]          out_r_data_i,
    input  logic                   out_r_valid_i,
    output logic                   err_o
`ifdef TCDM_ARB_PERF_EN
    ,
    output logic [NB_REQ*32-1:0]   perf_gnt_cnt_o,
    output logic [31:0]            perf_full_cyc_o
`endif
);

    localparam int unsigned IDW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int unsigned PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CW  = $clog2(MAX_OUTST + 1);
    localparam int unsigned BW  = DW / 8;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   sel_q, sel_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   win;
    logic             win_vld;
    logic [IDW-1:0]   cur_sel;
    logic             hs;
    logic             pop;
    logic             fifo_full;

    logic [IDW-1:0]   mem_q [MAX_OUTST];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q;

    // Advance a FIFO pointer, wrapping at MAX_OUTST (depth need not be a power of two).
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTST - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign fifo_full = (cnt_q == CW'(MAX_OUTST));

    // Round-robin search: first asserted request at or after ptr_q, wrapping.
    // Scanning from the farthest offset down leaves the nearest one as winner.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int j = NB_REQ - 1; j >= 0; j--) begin
            automatic int idx = (int'(ptr_q) + j) % int'(NB_REQ);
            if (in_req_i[idx]) begin
                win     = IDW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    // Master request: held on the locked requester, otherwise a fresh winner if the FIFO has room.
    always_comb begin
        out_req_o = 1'b0;
        cur_sel   = sel_q;
        if (state_q == LOCKED) begin
            out_req_o = 1'b1;
        end else if (win_vld && !fifo_full) begin
            out_req_o = 1'b1;
            cur_sel   = win;
        end
    end

    assign hs  = out_req_o & out_gnt_i;
    assign pop = out_r_valid_i & (cnt_q != '0);

    assign out_add_o  = in_add_i[int'(cur_sel)*AW +: AW];
    assign out_wen_o  = in_wen_i[cur_sel];
    assign out_be_o   = in_be_i[int'(cur_sel)*BW +: BW];
    assign out_data_o = in_data_i[int'(cur_sel)*DW +: DW];

    assign in_gnt_o     = hs  ? ({{(NB_REQ-1){1'b0}}, 1'b1} << cur_sel) : '0;
    assign in_r_valid_o = pop ? ({{(NB_REQ-1){1'b0}}, 1'b1} << mem_q[rptr_q]) : '0;
    assign in_r_data_o  = out_r_data_i;
    assign err_o        = err_q;

    // Next-state logic for the arbitration FSM and the round-robin pointer.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (hs) begin
            ptr_d = (cur_sel == IDW'(NB_REQ - 1)) ? '0 : cur_sel + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (out_req_o && !out_gnt_i) begin
                    state_d = LOCKED;
                    sel_d   = win;
                end
            end
            LOCKED: begin
                if (out_gnt_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbitration FSM state, locked selection and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    // Occupancy follows push/pop; simultaneous push and pop leave it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({hs, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // ID FIFO control pointers, occupancy and sticky orphan-response flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (hs)  wptr_q <= wrap_inc(wptr_q);
            if (pop) rptr_q <= wrap_inc(rptr_q);
            cnt_q <= cnt_d;
            if (out_r_valid_i && (cnt_q == '0)) err_q <= 1'b1;
        end
    end

    // ID FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk_i) begin
        if (hs) mem_q[wptr_q] <= cur_sel;
    end

`ifdef TCDM_ARB_PERF_EN
    logic [31:0] gnt_cnt_q [NB_REQ];
    logic [31:0] full_cyc_q;

    // Wrapping 32-bit event counters for handshakes and FIFO-full stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NB_REQ); i++) gnt_cnt_q[i] <= '0;
            full_cyc_q <= '0;
        end else begin
            for (int i = 0; i < int'(NB_REQ); i++) begin
                if (in_gnt_o[i]) gnt_cnt_q[i] <= gnt_cnt_q[i] + 32'd1;
            end
            if ((|in_req_i) && fifo_full) full_cyc_q <= full_cyc_q + 32'd1;
        end
    end

    for (genvar g = 0; g < int'(NB_REQ); g++) begin : g_perf
        assign perf_gnt_cnt_o[g*32 +: 32] = gnt_cnt_q[g];
    end
    assign perf_full_cyc_o = full_cyc_q;
`endif

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Bench for tcdm_rr_arbiter: directed scenarios plus randomized traffic, every
// cycle compared against a queue-based reference model of the arbiter.
module tb_tcdm_rr_arbiter;

    localparam int NB_REQ    = 4;
    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_OUTST = 2;

    logic                   clk;
    logic                   rst_n;
    logic [NB_REQ-1:0]      in_req;
    logic [NB_REQ*AW-1:0]   in_add;
    logic [NB_REQ-1:0]      in_wen;
    logic [NB_REQ*DW/8-1:0] in_be;
    logic [NB_REQ*DW-1:0]   in_data;
    logic [NB_REQ-1:0]      in_gnt;
    logic [DW-1:0]          in_r_data;
    logic [NB_REQ-1:0]      in_r_valid;
    logic                   out_req;
    logic [AW-1:0]          out_add;
    logic                   out_wen;
    logic [DW/8-1:0]        out_be;
    logic [DW-1:0]          out_data;
    logic                   out_gnt;
    logic [DW-1:0]          out_r_data;
    logic                   out_r_valid;
    logic                   err;
`ifdef TCDM_ARB_PERF_EN
    logic [NB_REQ*32-1:0]   perf_gnt_cnt;
    logic [31:0]            perf_full_cyc;
`endif

    tcdm_rr_arbiter #(
        .NB_REQ(NB_REQ), .AW(AW), .DW(DW), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_req_i     (in_req),
        .in_add_i     (in_add),
        .in_wen_i     (in_wen),
        .in_be_i      (in_be),
        .in_data_i    (in_data),
        .in_gnt_o     (in_gnt),
        .in_r_data_o  (in_r_data),
        .in_r_valid_o (in_r_valid),
        .out_req_o    (out_req),
        .out_add_o    (out_add),
        .out_wen_o    (out_wen),
        .out_be_o     (out_be),
        .out_data_o   (out_data),
        .out_gnt_i    (out_gnt),
        .out_r_data_i (out_r_data),
        .out_r_valid_i(out_r_valid),
        .err_o        (err)
`ifdef TCDM_ARB_PERF_EN
        ,
        .perf_gnt_cnt_o (perf_gnt_cnt),
        .perf_full_cyc_o(perf_full_cyc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    int   m_ptr;
    bit   m_locked;
    int   m_sel;
    bit   m_err;
    int   m_q[$];
    int   glog[$];
    logic [NB_REQ-1:0] last_gnt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_fields(input int i);
        in_add[i*AW +: AW]     = $urandom;
        in_wen[i]              = 1'($urandom_range(0, 1));
        in_be[i*(DW/8) +: DW/8] = 4'($urandom);
        in_data[i*DW +: DW]    = $urandom;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_locked = 0; m_sel = 0; m_err = 0;
        m_q.delete();
        glog.delete();
        last_gnt = '0;
    endtask

    // Called at a falling edge with inputs already driven; checks, then advances one cycle.
    task automatic step();
        int win;
        bit ereq;
        logic [NB_REQ-1:0] egnt, erv;
        #1;
        win = -1;
        ereq = 0;
        if (m_locked) begin
            ereq = 1;
            win  = m_sel;
        end else if (in_req != '0 && m_q.size() < MAX_OUTST) begin
            for (int j = 0; j < NB_REQ; j++)
                if (win < 0 && in_req[(m_ptr + j) % NB_REQ]) win = (m_ptr + j) % NB_REQ;
            ereq = 1;
        end
        egnt = (ereq && out_gnt) ? (4'b0001 << win) : '0;
        erv  = (out_r_valid && m_q.size() > 0) ? (4'b0001 << m_q[0]) : '0;
        check_val("out_req", out_req, ereq);
        if (ereq) begin
            check_val("out_add",  out_add,  in_add[win*AW +: AW]);
            check_val("out_wen",  out_wen,  in_wen[win]);
            check_val("out_be",   out_be,   in_be[win*(DW/8) +: DW/8]);
            check_val("out_data", out_data, in_data[win*DW +: DW]);
        end
        check_val("in_gnt",     in_gnt,     egnt);
        check_val("in_r_valid", in_r_valid, erv);
        check_val("in_r_data",  in_r_data,  out_r_data);
        check_val("err",        err,        m_err);
        last_gnt = egnt;
        @(posedge clk);
        if (out_r_valid) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_err = 1;
        end
        if (egnt != '0) begin
            m_q.push_back(win);
            glog.push_back(win);
            m_ptr = (win + 1) % NB_REQ;
            m_locked = 0;
        end else if (ereq) begin
            m_locked = 1;
            m_sel = win;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        in_req = '0;
        out_gnt = 1'b0;
        out_r_valid = 1'b0;
        #1;
        check_val("rst_out_req",    out_req,    0);
        check_val("rst_in_gnt",     in_gnt,     0);
        check_val("rst_in_r_valid", in_r_valid, 0);
        check_val("rst_err",        err,        0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic drain();
        in_req = '0;
        out_gnt = 1'b0;
        for (int k = 0; k < MAX_OUTST + 1; k++) begin
            out_r_valid = (m_q.size() > 0);
            out_r_data  = $urandom;
            step();
        end
        out_r_valid = 1'b0;
    endtask

    initial begin
        int n0;
        rst_n = 1'b0;
        in_req = '0; in_add = '0; in_wen = '0; in_be = '0; in_data = '0;
        out_gnt = 1'b0; out_r_data = '0; out_r_valid = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();
        for (int i = 0; i < NB_REQ; i++) set_fields(i);

        // T1: all requesting, memory always grants and answers next cycle
        in_req = 4'b1111;
        out_gnt = 1'b1;
        for (int k = 0; k < 8; k++) begin
            out_r_valid = (m_q.size() > 0);
            out_r_data  = $urandom;
            step();
        end
        check_val("t1_count", glog.size(), 8);
        for (int k = 0; k < 8 && k < glog.size(); k++) check_val("t1_order", glog[k], k % 4);
        drain();

        // T2: requester 2 waits two cycles for grant; requester 0 arrives mid-wait
        glog.delete();
        in_req = 4'b0100;
        out_gnt = 1'b0;
        step();
        in_req = 4'b0101;
        step();
        out_gnt = 1'b1;
        step();
        in_req = 4'b0001;
        step();
        check_val("t2_count", glog.size(), 2);
        if (glog.size() == 2) begin
            check_val("t2_first",  glog[0], 2);
            check_val("t2_second", glog[1], 0);
        end
        drain();

        // T3: FIFO fills after two grants and blocks until a response arrives
        glog.delete();
        in_req = 4'b1111;
        out_gnt = 1'b1;
        out_r_valid = 1'b0;
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            step();
        end
        check_val("t3_blocked", glog.size(), 2);
        out_r_valid = 1'b1;
        out_r_data = 32'hA5A5_0001;
        #1;
        check_val("t3_route", in_r_valid, (glog.size() > 0) ? (4'b0001 << glog[0]) : 4'b0000);
        step();
        out_r_valid = 1'b0;
        n0 = glog.size();
        step();
        check_val("t3_regrant", glog.size(), n0 + 1);
        drain();

        // T4: back-to-back grants to 1 and 3, responses routed in order
        do_reset();
        in_req = 4'b1010;
        out_gnt = 1'b1;
        step();
        in_req = 4'b1000;
        step();
        in_req = '0;
        out_r_valid = 1'b1;
        out_r_data = 32'hDEAD_BEEF;
        #1;
        check_val("t4_rv1", in_r_valid, 4'b0010);
        check_val("t4_rd1", in_r_data, 32'hDEAD_BEEF);
        step();
        out_r_data = 32'h1234_5678;
        #1;
        check_val("t4_rv2", in_r_valid, 4'b1000);
        check_val("t4_rd2", in_r_data, 32'h1234_5678);
        step();
        out_r_valid = 1'b0;
        step();

        // T5: orphan response sets the sticky error flag
        do_reset();
        out_r_valid = 1'b1;
        out_r_data = $urandom;
        step();
        out_r_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check_val("t5_sticky", err, 1);

        // T6: reset while locked with a transaction outstanding
        do_reset();
        in_req = 4'b0001;
        out_gnt = 1'b1;
        step();
        in_req = 4'b0100;
        out_gnt = 1'b0;
        step();
        check_val("t6_locked", out_req, 1);
        do_reset();
        in_req = 4'b1010;
        out_gnt = 1'b1;
        step();
        check_val("t6_first", (glog.size() > 0) ? glog[0] : -1, 1);
        drain();

        // Randomized traffic: requesters hold until granted, memory grants and answers randomly
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NB_REQ; i++) begin
                if (!in_req[i] && $urandom_range(0, 2) == 0) begin
                    in_req[i] = 1'b1;
                    set_fields(i);
                end
            end
            out_gnt     = ($urandom_range(0, 3) != 0);
            out_r_valid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            out_r_data  = $urandom;
            step();
            for (int i = 0; i < NB_REQ; i++) begin
                if (last_gnt[i]) begin
                    if ($urandom_range(0, 1) == 1) in_req[i] = 1'b0;
                    else set_fields(i);
                end
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
